// File: rtl/sim_spi_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : sim_spi_host_seq
// Purpose  : Byte-stream SPI mode-0 host (MSB first) with per-frame chip select.
// Revision : 1.0 - initial release
// ============================================================================
module sim_spi_host_seq #(
    parameter int ClkDiv   = 4,
    parameter int CsbSetup = 2,
    parameter int CsbIdle  = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [7:0] cmd_data_i,
    input  logic       cmd_last_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    input  logic       rsp_ready_i,
    output logic       spi_device_sck_o,
    output logic       spi_device_csb_o,
    output logic       spi_device_sdi_o,
    input  logic       spi_device_sdo_i,
    input  logic       spi_device_sdo_en_i,
    output logic       busy_o
);

    localparam int MAX_AB  = (ClkDiv > CsbSetup) ? ClkDiv : CsbSetup;
    localparam int MAX_CNT = (MAX_AB > CsbIdle) ? MAX_AB : CsbIdle;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] DIV_END   = CNT_W'(ClkDiv - 1);
    localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(CsbSetup - 1);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(CsbIdle - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic             last_q, last_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             sck_q, sck_d;
    logic             csb_q, csb_d;
    logic             sdi_q, sdi_d;
    logic             cmd_hs;
    logic             sample;

    // Accepting a byte only when the response slot is free (or freeing now)
    // keeps the single response register from ever being overwritten.
    assign cmd_ready_o = ((state_q == S_IDLE) || (state_q == S_WAIT)) &&
                         (!rsp_valid_q || rsp_ready_i);
    assign cmd_hs      = cmd_valid_i && cmd_ready_o;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        sck_d       = sck_q;
        csb_d       = csb_q;
        sdi_d       = sdi_q;
        sample      = spi_device_sdo_en_i ? spi_device_sdo_i : 1'b1;

        if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    tx_d    = cmd_data_i;
                    last_d  = cmd_last_i;
                    cnt_d   = '0;
                    csb_d   = 1'b0;
                    sdi_d   = cmd_data_i[7];
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_END) begin
                    cnt_d   = '0;
                    bit_d   = 3'd7;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_SHIFT: begin
                // SCK is already high on this cycle: first cycle of the high phase.
                if (sck_q && (cnt_q == '0)) begin
                    rx_d = {rx_q[6:0], sample};
                end
                if (cnt_q != DIV_END) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == 3'd0) begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = rx_d;
                            csb_d       = last_q;
                            state_d     = last_q ? S_GAP : S_WAIT;
                        end else begin
                            bit_d = bit_q - 3'd1;
                            sdi_d = tx_q[bit_q - 3'd1];
                        end
                    end
                end
            end
            S_WAIT: begin
                if (cmd_hs) begin
                    tx_d    = cmd_data_i;
                    last_d  = cmd_last_i;
                    cnt_d   = '0;
                    bit_d   = 3'd7;
                    sdi_d   = cmd_data_i[7];
                    state_d = S_SHIFT;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_END) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                csb_d   = 1'b1;
                sck_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            tx_q        <= 8'h00;
            rx_q        <= 8'h00;
            last_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            sck_q       <= 1'b0;
            csb_q       <= 1'b1;
            sdi_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            sck_q       <= sck_d;
            csb_q       <= csb_d;
            sdi_q       <= sdi_d;
        end
    end

    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_data_o       = rsp_data_q;
    assign spi_device_sck_o = sck_q;
    assign spi_device_csb_o = csb_q;
    assign spi_device_sdi_o = sdi_q;
    assign busy_o           = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sim_spi_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sim_spi_host_seq
// Purpose  : Self-checking bench for sim_spi_host_seq (ClkDiv=2 and ClkDiv=1 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sim_spi_host_seq;

    localparam int D           = 2;
    localparam int S           = 2;
    localparam int G           = 2;
    localparam int SHIFT_START = 1 + S;
    localparam int BYTE_END    = S + 16 * D;
    localparam int RSP_AT      = BYTE_END + 1;
    localparam int IDLE_AT     = RSP_AT + G;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0, cmd_ready, cmd_last = 1'b0;
    logic [7:0] cmd_data = 8'h00, rsp_data;
    logic       rsp_valid, rsp_ready = 1'b1;
    logic       sck, csb, sdi, sdo, sdo_en = 1'b1, busy;

    logic       k_cmd_valid = 1'b0, k_cmd_ready, k_cmd_last = 1'b1;
    logic [7:0] k_cmd_data = 8'h00, k_rsp_data;
    logic       k_rsp_valid, k_rsp_ready = 1'b1;
    logic       k_sck, k_csb, k_sdi, k_sdo, k_busy;

    sim_spi_host_seq #(.ClkDiv(D), .CsbSetup(S), .CsbIdle(G)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_data_i(cmd_data),
        .cmd_last_i(cmd_last), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
        .rsp_ready_i(rsp_ready), .spi_device_sck_o(sck), .spi_device_csb_o(csb),
        .spi_device_sdi_o(sdi), .spi_device_sdo_i(sdo), .spi_device_sdo_en_i(sdo_en),
        .busy_o(busy)
    );

    sim_spi_host_seq #(.ClkDiv(1), .CsbSetup(S), .CsbIdle(G)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(k_cmd_valid), .cmd_ready_o(k_cmd_ready), .cmd_data_i(k_cmd_data),
        .cmd_last_i(k_cmd_last), .rsp_valid_o(k_rsp_valid), .rsp_data_o(k_rsp_data),
        .rsp_ready_i(k_rsp_ready), .spi_device_sck_o(k_sck), .spi_device_csb_o(k_csb),
        .spi_device_sdi_o(k_sdi), .spi_device_sdo_i(k_sdo), .spi_device_sdo_en_i(1'b1),
        .busy_o(k_busy)
    );

    // Mode-0 device: presents the next bit after each SCK fall, bit 7 on CSB fall.
    logic [7:0] dev_bytes [4];
    int         dev_nbit = 0;
    logic [1:0] byte_sel;
    logic [2:0] bit_sel;
    always @(negedge csb) dev_nbit = 0;
    always @(negedge sck) if (!csb) dev_nbit = dev_nbit + 1;
    assign byte_sel = dev_nbit[4:3];
    assign bit_sel  = 3'd7 - dev_nbit[2:0];
    assign sdo      = dev_bytes[byte_sel][bit_sel];

    logic [7:0] k_dev = 8'h00;
    int         k_nbit = 0;
    logic [2:0] k_bit_sel;
    always @(negedge k_csb) k_nbit = 0;
    always @(negedge k_sck) if (!k_csb) k_nbit = k_nbit + 1;
    assign k_bit_sel = 3'd7 - k_nbit[2:0];
    assign k_sdo     = k_dev[k_bit_sel];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b1; cmd_data = 8'hFF; cmd_last = 1'b1;
        step(); step();
        checks++; if (csb !== 1'b1) begin failures++; $display("FAIL reset_csb got=%b exp=1", csb); end
        checks++; if (sck !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", sck); end
        checks++; if (sdi !== 1'b0) begin failures++; $display("FAIL reset_sdi got=%b exp=0", sdi); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (k_csb !== 1'b1 || k_busy !== 1'b0) begin failures++; $display("FAIL reset_dut1 got csb=%b busy=%b exp csb=1 busy=0", k_csb, k_busy); end
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_byte(input logic [7:0] cmd, input logic [7:0] dev);
        int rel;
        logic e_sck;
        dev_bytes[0] = dev; sdo_en = 1'b1; rsp_ready = 1'b1;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL sb_ready_c0 got=%b exp=1", cmd_ready); end
        cmd_valid = 1'b1; cmd_data = cmd; cmd_last = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int c = 1; c <= IDLE_AT; c++) begin
            rel = c - SHIFT_START;
            e_sck = 1'b0;
            if (rel >= 0 && rel < 16 * D) e_sck = ((rel % (2 * D)) >= D);
            checks++; if (sck !== e_sck) begin failures++; $display("FAIL sb_sck c=%0d got=%b exp=%b", c, sck, e_sck); end
            checks++; if (csb !== (c > BYTE_END)) begin failures++; $display("FAIL sb_csb c=%0d got=%b exp=%b", c, csb, c > BYTE_END); end
            checks++; if (rsp_valid !== (c == RSP_AT)) begin failures++; $display("FAIL sb_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, c == RSP_AT); end
            checks++; if (cmd_ready !== (c >= IDLE_AT)) begin failures++; $display("FAIL sb_cmd_ready c=%0d got=%b exp=%b", c, cmd_ready, c >= IDLE_AT); end
            checks++; if (busy !== (c < IDLE_AT)) begin failures++; $display("FAIL sb_busy c=%0d got=%b exp=%b", c, busy, c < IDLE_AT); end
            if (rel >= 0 && rel < 16 * D && (rel % (2 * D)) == D) begin
                checks++; if (sdi !== cmd[7 - rel / (2 * D)]) begin failures++; $display("FAIL sb_sdi c=%0d got=%b exp=%b", c, sdi, cmd[7 - rel / (2 * D)]); end
            end
            if (c == RSP_AT) begin
                checks++; if (rsp_data !== dev) begin failures++; $display("FAIL sb_rsp_data got=%h exp=%h", rsp_data, dev); end
            end
            if (c != IDLE_AT) step();
        end
    endtask

    task automatic test_sdo_disabled(input logic [7:0] cmd, input logic [7:0] dev);
        dev_bytes[0] = dev; sdo_en = 1'b0; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_data = cmd; cmd_last = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int c = 1; c <= IDLE_AT; c++) begin
            checks++; if (rsp_valid !== (c == RSP_AT)) begin failures++; $display("FAIL dis_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, c == RSP_AT); end
            if (c == RSP_AT) begin
                checks++; if (rsp_data !== 8'hFF) begin failures++; $display("FAIL dis_rsp_data got=%h exp=ff", rsp_data); end
            end
            if (c != IDLE_AT) step();
        end
        sdo_en = 1'b1;
    endtask

    task automatic test_two_byte(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] d0, input logic [7:0] d1);
        int r1, r2;
        int end2, rsp2, idle2;
        logic e_sck;
        end2 = RSP_AT + 16 * D; rsp2 = end2 + 1; idle2 = rsp2 + G;
        dev_bytes[0] = d0; dev_bytes[1] = d1; sdo_en = 1'b1; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_data = b0; cmd_last = 1'b0;
        step();
        for (int c = 1; c <= idle2; c++) begin
            cmd_valid = 1'b0;
            r1 = c - SHIFT_START;
            r2 = c - (RSP_AT + 1);
            e_sck = 1'b0;
            if (r1 >= 0 && r1 < 16 * D) e_sck = ((r1 % (2 * D)) >= D);
            if (r2 >= 0 && r2 < 16 * D) e_sck = ((r2 % (2 * D)) >= D);
            checks++; if (sck !== e_sck) begin failures++; $display("FAIL tb_sck c=%0d got=%b exp=%b", c, sck, e_sck); end
            checks++; if (csb !== (c > end2)) begin failures++; $display("FAIL tb_csb c=%0d got=%b exp=%b", c, csb, c > end2); end
            checks++; if (rsp_valid !== (c == RSP_AT || c == rsp2)) begin failures++; $display("FAIL tb_rsp_valid c=%0d got=%b", c, rsp_valid); end
            checks++; if (busy !== (c < idle2)) begin failures++; $display("FAIL tb_busy c=%0d got=%b exp=%b", c, busy, c < idle2); end
            if (r1 >= 0 && r1 < 16 * D && (r1 % (2 * D)) == D) begin
                checks++; if (sdi !== b0[7 - r1 / (2 * D)]) begin failures++; $display("FAIL tb_sdi0 c=%0d got=%b exp=%b", c, sdi, b0[7 - r1 / (2 * D)]); end
            end
            if (r2 >= 0 && r2 < 16 * D && (r2 % (2 * D)) == D) begin
                checks++; if (sdi !== b1[7 - r2 / (2 * D)]) begin failures++; $display("FAIL tb_sdi1 c=%0d got=%b exp=%b", c, sdi, b1[7 - r2 / (2 * D)]); end
            end
            if (c == RSP_AT) begin
                checks++; if (rsp_data !== d0) begin failures++; $display("FAIL tb_rsp0 got=%h exp=%h", rsp_data, d0); end
                checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL tb_wait_ready got=%b exp=1", cmd_ready); end
                cmd_valid = 1'b1; cmd_data = b1; cmd_last = 1'b1;
            end
            if (c == rsp2) begin
                checks++; if (rsp_data !== d1) begin failures++; $display("FAIL tb_rsp1 got=%h exp=%h", rsp_data, d1); end
            end
            if (c != idle2) step();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_backpressure(input logic [7:0] b0, input logic [7:0] b1,
                                     input logic [7:0] d0, input logic [7:0] d1);
        int n;
        dev_bytes[0] = d0; dev_bytes[1] = d1; sdo_en = 1'b1; rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_data = b0; cmd_last = 1'b0;
        step();
        cmd_valid = 1'b0;
        n = 1;
        while (rsp_valid !== 1'b1 && n < 200) begin step(); n++; end
        checks++; if (n != RSP_AT) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", n, RSP_AT); end
        checks++; if (rsp_data !== d0) begin failures++; $display("FAIL bp_rsp0 got=%h exp=%h", rsp_data, d0); end
        cmd_valid = 1'b1; cmd_data = b1; cmd_last = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_cmd_ready i=%0d got=%b exp=0", i, cmd_ready); end
            checks++; if (csb !== 1'b0 || sck !== 1'b0) begin failures++; $display("FAIL bp_pins i=%0d got csb=%b sck=%b exp 0 0", i, csb, sck); end
            checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL bp_hold i=%0d got valid=%b busy=%b exp 1 1", i, rsp_valid, busy); end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", cmd_ready); end
        step();
        cmd_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_consumed got=%b exp=0", rsp_valid); end
        checks++; if (csb !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL bp_second_start got csb=%b busy=%b exp 0 1", csb, busy); end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin step(); n++; end
        checks++; if (n != 16 * D) begin failures++; $display("FAIL bp_latency2 got=%0d exp=%0d", n, 16 * D); end
        checks++; if (rsp_data !== d1) begin failures++; $display("FAIL bp_rsp1 got=%h exp=%h", rsp_data, d1); end
        n = 0;
        while (busy !== 1'b0 && n < 50) begin step(); n++; end
        checks++; if (n != G) begin failures++; $display("FAIL bp_gap got=%0d exp=%0d", n, G); end
    endtask

    task automatic test_reset_mid_byte(input logic [7:0] dev);
        dev_bytes[0] = 8'h00; sdo_en = 1'b1; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_data = 8'hFF; cmd_last = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (9) step();
        checks++; if (sdi !== 1'b1 || csb !== 1'b0) begin failures++; $display("FAIL rm_pre got sdi=%b csb=%b exp 1 0", sdi, csb); end
        rst_n = 1'b0;
        #1;
        checks++; if (csb !== 1'b1) begin failures++; $display("FAIL rm_csb got=%b exp=1", csb); end
        checks++; if (sck !== 1'b0) begin failures++; $display("FAIL rm_sck got=%b exp=0", sck); end
        checks++; if (sdi !== 1'b0) begin failures++; $display("FAIL rm_sdi got=%b exp=0", sdi); end
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin failures++; $display("FAIL rm_rsp got valid=%b data=%h exp 0 00", rsp_valid, rsp_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", busy); end
        step(); step();
        rst_n = 1'b1;
        step();
        dev_bytes[0] = dev;
        cmd_valid = 1'b1; cmd_data = 8'h5A; cmd_last = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int c = 1; c <= IDLE_AT; c++) begin
            if (c <= S) begin
                checks++; if (csb !== 1'b0 || sck !== 1'b0) begin failures++; $display("FAIL rm_setup c=%0d got csb=%b sck=%b exp 0 0", c, csb, sck); end
            end
            checks++; if (rsp_valid !== (c == RSP_AT)) begin failures++; $display("FAIL rm_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, c == RSP_AT); end
            if (c == RSP_AT) begin
                checks++; if (rsp_data !== dev) begin failures++; $display("FAIL rm_rsp_data got=%h exp=%h", rsp_data, dev); end
            end
            if (c != IDLE_AT) step();
        end
    endtask

    task automatic test_clkdiv1(input logic [7:0] cmd, input logic [7:0] dev);
        int rel;
        logic e_sck;
        k_dev = dev; k_rsp_ready = 1'b1;
        k_cmd_valid = 1'b1; k_cmd_data = cmd; k_cmd_last = 1'b1;
        step();
        k_cmd_valid = 1'b0;
        for (int c = 1; c <= 1 + S + 16 + G; c++) begin
            rel = c - SHIFT_START;
            e_sck = 1'b0;
            if (rel >= 0 && rel < 16) e_sck = ((rel % 2) == 1);
            checks++; if (k_sck !== e_sck) begin failures++; $display("FAIL k1_sck c=%0d got=%b exp=%b", c, k_sck, e_sck); end
            checks++; if (k_csb !== (c > S + 16)) begin failures++; $display("FAIL k1_csb c=%0d got=%b exp=%b", c, k_csb, c > S + 16); end
            checks++; if (k_rsp_valid !== (c == 1 + S + 16)) begin failures++; $display("FAIL k1_rsp_valid c=%0d got=%b exp=%b", c, k_rsp_valid, c == 1 + S + 16); end
            if (rel >= 0 && rel < 16 && (rel % 2) == 1) begin
                checks++; if (k_sdi !== cmd[7 - rel / 2]) begin failures++; $display("FAIL k1_sdi c=%0d got=%b exp=%b", c, k_sdi, cmd[7 - rel / 2]); end
            end
            if (c == 1 + S + 16) begin
                checks++; if (k_rsp_data !== dev) begin failures++; $display("FAIL k1_rsp_data got=%h exp=%h", k_rsp_data, dev); end
            end
            step();
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_byte(8'hA5, 8'h3C);
        repeat (3) test_single_byte(8'($urandom), 8'($urandom));
        test_sdo_disabled(8'($urandom), 8'($urandom));
        test_two_byte(8'h9F, 8'h00, 8'($urandom), 8'($urandom));
        repeat (2) test_two_byte(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        test_backpressure(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        test_reset_mid_byte(8'($urandom));
        test_clkdiv1(8'($urandom), 8'($urandom));
        test_clkdiv1(8'($urandom), 8'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/sim_spi_host_seq.md
# sim_spi_host_seq

Simulation-harness SPI host sequencer for the Verilator top. It drives the `spi_device` pins of `top_earlgrey` from a byte-wide command stream and returns the bytes captured on SDO, giving C++/DPI testbenches a cycle-deterministic SPI host. It uses SPI mode 0 with MSB first and controls chip select per command frame.

## Interface
- `ClkDiv`, default 4: SCK half-period in `clk_i` cycles; must be ≥1.
- `CsbSetup`, default 2: cycles CSB is low before the first SCK phase of a frame; must be ≥1.
- `CsbIdle`, default 2: minimum CSB-high gap after a frame, in cycles; must be ≥1.
- `clk_i  in  1  clock; single clock domain.`
- `rst_ni  in  1  asynchronous active-low reset.`
- `cmd_valid_i  in  1  command byte valid.`
- `cmd_ready_o  out  1  command byte accepted when both valid and ready are high.`
- `cmd_data_i  in  8  byte to shift out on SDI.`
- `cmd_last_i  in  1  this byte ends the frame; CSB deasserts after it.`
- `rsp_valid_o  out  1  captured byte available.`
- `rsp_data_o  out  8  byte captured from SDO.`
- `rsp_ready_i  in  1  consumer accepts the response.`
- `spi_device_sck_o  out  1  SCK; idles low.`
- `spi_device_csb_o  out  1  chip select, active low.`
- `spi_device_sdi_o  out  1  host-to-device data.`
- `spi_device_sdo_i  in  1  device-to-host data.`
- `spi_device_sdo_en_i  in  1  device SDO output enable.`
- `busy_o  out  1  high whenever the FSM is not in Idle.`

## Operation
- **FSM states:** Idle, Setup, Shift, WaitCmd, Gap.
- **`cmd_ready_o`:** equals (state is Idle or WaitCmd) && (!rsp_valid_o || rsp_ready_i). This rule means the single response register can never overflow.
- **Idle:**
  - CSB=1, SCK=0.
  - On a command handshake, latch the data and last flag, then go to Setup.
- **Setup:**
  - CSB=0, SCK=0, SDI=bit7.
  - Lasts `CsbSetup` cycles, then go to Shift.
- **Shift:**
  - Each bit takes `ClkDiv` cycles with SCK=0, then `ClkDiv` cycles with SCK=1.
  - SDI changes only at the start of a low phase and is stable for the whole bit.
  - SDO is sampled on the cycle SCK rises. If `spi_device_sdo_en_i`=0 at the sample point, the captured bit is 1 (pull-up).
  - Bit order is 7 down to 0. A 3-bit bit counter and a phase counter of width $clog2(ClkDiv) are sufficient.
- **End of byte:**
  - On the cycle after bit0's high phase: load the response register, set rsp_valid_o=1, SCK=0.
  - Next state is Gap if the latched last flag is 1, otherwise WaitCmd.
- **WaitCmd:**
  - CSB stays 0, SCK=0, SDI holds its previous value.
  - A command handshake moves straight to Shift with no re-setup. The FSM waits indefinitely.
- **Gap:** CSB=1 for `CsbIdle` cycles, then go to Idle.
- **Response register:** rsp_valid_o stays high until an rsp_ready_i handshake, then clears on the next cycle.
- **Reset:** all state is cleared asynchronously, including when reset asserts mid-frame. A pending response is discarded.

## Timing
- **Reset values:**
  - spi_device_csb_o=1, spi_device_sck_o=0, spi_device_sdi_o=0.
  - rsp_valid_o=0, rsp_data_o=0, busy_o=0.
  - cmd_ready_o=1 (Idle, no pending response); handshakes during reset are ignored.
- **Registered outputs:** all pin outputs are registered and glitch-free. cmd_ready_o is combinational from state.
- **Frame timing:** for a handshake at cycle 0:
  - Setup occupies cycles 1..CsbSetup.
  - Byte shift takes 16·ClkDiv cycles.
  - rsp_valid_o rises at cycle 1+CsbSetup+16·ClkDiv.
- **Back-to-back bytes:** a handshake in WaitCmd at cycle t starts the next low phase at cycle t+1.
- **Simultaneous events:** rsp_ready_i and a command handshake may occur in the same cycle in WaitCmd or Idle.

## Test plan
All scenarios use ClkDiv=2, CsbSetup=2, CsbIdle=2.
- **Single byte:** cmd 0xA5 with last=1 at cycle 0; device drives SDO 0x3C with sdo_en=1.
  - SDI bits 1,0,1,0,0,1,0,1 are seen at the SCK rising edges at cycles 5,9,…,33.
  - CSB is low for cycles 1–34.
  - rsp 0x3C is valid at cycle 35; CSB=1 at 35; cmd_ready_o=0 for cycles 35–36 and 1 at 37.
- **Two-byte frame:** 0x9F (last=0) then 0x00 (last=1), with the second handshake at cycle 35.
  - CSB stays low continuously from cycle 1 to cycle 67.
  - The second byte's shift spans cycles 36–67, and two responses are returned in order.
- **SDO disabled:** sdo_en_i=0 for the whole byte → rsp_data_o=0xFF.
- **Response backpressure:** rsp_ready_i=0 after a non-last byte.
  - cmd_ready_o stays 0 and the FSM holds WaitCmd with CSB=0 and SCK=0 for 20 cycles.
  - Raising rsp_ready_i while cmd_valid_i=1 gives a same-cycle handshake on both streams.
- **Reset mid-byte:** rst_ni asserted at cycle 10.
  - CSB=1, SCK=0, SDI=0 and rsp_valid_o=0 immediately.
  - After release, a new cmd 0x5A runs a full Setup and returns the correct response.
- **ClkDiv=1 build:** one byte takes 16 cycles of shift, and rsp_valid_o rises at cycle 19.
